// File: rtl/conv_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | conv_pkg : row geometry, datapath widths and sequencer state type |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
package conv_pkg;

  localparam int c_I_X     = 8;
  localparam int c_I_W     = 8;
  localparam int c_I_PSUM  = 16;
  localparam int c_O_SAT   = 16;
  localparam int c_TAPS    = 5;
  localparam int c_LATENCY = 5;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    RUN  = 2'd1,
    OUT  = 2'd2
  } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/conv_tap_buffer.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | conv_tap_buffer : TAPS-entry x/w register file, beat-indexed      |
// | write, idx-indexed read that returns 0 past the last tap. Rev 1.0 |
// +-------------------------------------------------------------------+
module conv_tap_buffer
  import conv_pkg::*;
#(
  parameter int I_X  = c_I_X,
  parameter int I_W  = c_I_W,
  parameter int TAPS = c_TAPS,
  parameter int WA_W = 3,
  parameter int RA_W = 3
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_wr_en,
  input  logic [WA_W-1:0] i_wr_addr,
  input  logic [I_X-1:0]  i_wr_x,
  input  logic [I_W-1:0]  i_wr_w,
  input  logic [RA_W-1:0] i_rd_addr,
  output logic [I_X-1:0]  o_rd_x,
  output logic [I_W-1:0]  o_rd_w
);

  logic [I_X-1:0] r_x [TAPS];
  logic [I_W-1:0] r_w [TAPS];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < TAPS; k++) begin
        r_x[k] <= '0;
        r_w[k] <= '0;
      end
    end else if (i_wr_en) begin
      r_x[i_wr_addr] <= i_wr_x;
      r_w[i_wr_addr] <= i_wr_w;
    end
  end

  // Compare-and-select read keeps idx values beyond the last tap at zero.
  always_comb begin
    o_rd_x = '0;
    o_rd_w = '0;
    for (int k = 0; k < TAPS; k++) begin
      if (i_rd_addr == RA_W'(k)) begin
        o_rd_x = r_x[k];
        o_rd_w = r_w[k];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/conv_line_sequencer.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | conv_line_sequencer : loads one window of (x,w) pairs, streams it |
// | into the conv row and returns the row result. Rev 1.0             |
// +-------------------------------------------------------------------+
module conv_line_sequencer
  import conv_pkg::*;
#(
  parameter int I_X     = c_I_X,
  parameter int I_W     = c_I_W,
  parameter int I_PSUM  = c_I_PSUM,
  parameter int O_SAT   = c_O_SAT,
  parameter int TAPS    = c_TAPS,
  parameter int LATENCY = c_LATENCY
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_in_valid,
  output logic                     o_in_ready,
  input  logic signed [I_X-1:0]    i_in_x,
  input  logic signed [I_W-1:0]    i_in_w,
  input  logic signed [I_PSUM-1:0] i_in_psum,
  output logic signed [I_X-1:0]    o_x,
  output logic signed [I_W-1:0]    o_w,
  output logic signed [I_PSUM-1:0] o_psum,
  input  logic signed [O_SAT-1:0]  i_line_psum,
  output logic                     o_out_valid,
  input  logic                     i_out_ready,
  output logic signed [O_SAT-1:0]  o_out_data,
  output logic                     o_busy
);

  localparam int c_BEAT_W = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int c_IDX_W  = $clog2(LATENCY + 1);

  seq_state_t                r_state;
  seq_state_t                w_state_nxt;
  logic [c_BEAT_W-1:0]       r_beat;
  logic [c_IDX_W-1:0]        r_idx;
  logic signed [I_PSUM-1:0]  r_psum_init;
  logic signed [O_SAT-1:0]   r_out_data;
  logic [I_X-1:0]            w_rd_x;
  logic [I_W-1:0]            w_rd_w;
  logic                      w_accept;
  logic                      w_last_beat;
  logic                      w_run_done;

  assign w_accept    = (r_state == LOAD) && i_in_valid;
  assign w_last_beat = (r_beat == c_BEAT_W'(TAPS - 1));
  assign w_run_done  = (r_idx == c_IDX_W'(LATENCY));
  assign o_out_data  = r_out_data;

  conv_tap_buffer #(
    .I_X  (I_X),
    .I_W  (I_W),
    .TAPS (TAPS),
    .WA_W (c_BEAT_W),
    .RA_W (c_IDX_W)
  ) u_tap_buffer (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_wr_en   (w_accept),
    .i_wr_addr (r_beat),
    .i_wr_x    (i_in_x),
    .i_wr_w    (i_in_w),
    .i_rd_addr (r_idx),
    .o_rd_x    (w_rd_x),
    .o_rd_w    (w_rd_w)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= LOAD;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    o_in_ready  = 1'b0;
    o_out_valid = 1'b0;
    o_busy      = 1'b0;
    o_x         = '0;
    o_w         = '0;
    o_psum      = '0;
    case (r_state)
      LOAD: begin
        o_in_ready = 1'b1;
        if (i_in_valid && w_last_beat) w_state_nxt = RUN;
      end
      RUN: begin
        o_busy = 1'b1;
        o_x    = w_rd_x;
        o_w    = w_rd_w;
        // The initial partial sum enters the row alongside tap 0 only.
        if (r_idx == '0) o_psum = r_psum_init;
        if (w_run_done) w_state_nxt = OUT;
      end
      OUT: begin
        o_busy      = 1'b1;
        o_out_valid = 1'b1;
        if (i_out_ready) w_state_nxt = LOAD;
      end
      default: w_state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_beat <= '0;
    end else if (w_accept) begin
      r_beat <= w_last_beat ? '0 : r_beat + c_BEAT_W'(1);
    end else if (r_state == OUT) begin
      r_beat <= '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_idx <= '0;
    end else if ((r_state == RUN) && !w_run_done) begin
      r_idx <= r_idx + c_IDX_W'(1);
    end else begin
      r_idx <= '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_psum_init <= '0;
      r_out_data  <= '0;
    end else begin
      if (w_accept && (r_beat == '0)) r_psum_init <= i_in_psum;
      if ((r_state == RUN) && w_run_done) r_out_data <= i_line_psum;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_conv_line_sequencer.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | tb_conv_line_sequencer : sequencer driving a five-PE saturating   |
// | row, checked cycle by cycle against a window-level model. Rev 1.0 |
// +-------------------------------------------------------------------+
module tb_conv_line_sequencer;
  import conv_pkg::*;

  localparam int TAPS    = c_TAPS;
  localparam int LATENCY = c_LATENCY;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [7:0]  in_x = '0;
  logic signed [7:0]  in_w = '0;
  logic signed [15:0] in_psum = '0;
  logic signed [7:0]  o_x;
  logic signed [7:0]  o_w;
  logic signed [15:0] o_psum;
  logic signed [15:0] line_psum;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic signed [15:0] out_data;
  logic               busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_acc_cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  conv_line_sequencer dut (
    .i_clk(clk), .i_rst(rst),
    .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_in_x(in_x), .i_in_w(in_w), .i_in_psum(in_psum),
    .o_x(o_x), .o_w(o_w), .o_psum(o_psum),
    .i_line_psum(line_psum),
    .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_out_data(out_data), .o_busy(busy)
  );

  function automatic int sat16(int v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // Five-PE systolic row: PE k adds its product on the cycle tap k is driven.
  int row_acc [TAPS];
  always @(posedge clk) begin
    row_acc[0] <= int'(o_psum) + int'(o_x) * int'(o_w);
    for (int k = 1; k < TAPS; k++)
      row_acc[k] <= row_acc[k-1] + int'(o_x) * int'(o_w);
  end
  always_comb line_psum = 16'(sat16(row_acc[TAPS-1]));

  task automatic chk(input string name, input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Window-level model: m_since counts cycles after the last accepted beat.
  bit m_live = 1'b0;
  int m_beats, m_since, m_psum, m_exp, m_data;
  int mx [TAPS];
  int mw [TAPS];

  always @(negedge clk) begin
    int  idx;
    bit  run;
    int  dot;
    if (m_live) begin
      run = (m_since > 0) && (m_since <= LATENCY + 1);
      idx = m_since - 1;
      chk("in_ready",  in_ready,  (m_since < 0) ? 1 : 0);
      chk("busy",      busy,      (m_since > 0) ? 1 : 0);
      chk("out_valid", out_valid, (m_since >= LATENCY + 2) ? 1 : 0);
      chk("row_x",     o_x,       (run && idx < TAPS) ? mx[idx] : 0);
      chk("row_w",     o_w,       (run && idx < TAPS) ? mw[idx] : 0);
      chk("row_psum",  o_psum,    (run && idx == 0) ? m_psum : 0);
      chk("out_data",  out_data,  m_data);
    end
    if (rst) begin
      m_live  = 1'b1;
      m_beats = 0;
      m_since = -1;
      m_data  = 0;
      m_psum  = 0;
    end else if (m_live) begin
      if (m_since < 0) begin
        if (in_valid) begin
          mx[m_beats] = in_x;
          mw[m_beats] = in_w;
          if (m_beats == 0) m_psum = in_psum;
          m_beats++;
          if (m_beats == TAPS) begin
            dot = m_psum;
            for (int k = 0; k < TAPS; k++) dot += mx[k] * mw[k];
            m_exp   = sat16(dot);
            m_since = 1;
          end
        end
      end else if (m_since >= LATENCY + 2) begin
        if (out_ready) begin
          m_since = -1;
          m_beats = 0;
        end
      end else begin
        if (m_since == LATENCY + 1) m_data = m_exp;
        m_since++;
      end
    end
  end

  int wx [TAPS];
  int ww [TAPS];
  int wpsum;

  task automatic send_beat(input int x, input int w, input int p);
    int   n;
    logic acc;
    in_valid = 1'b1; in_x = 8'(x); in_w = 8'(w); in_psum = 16'(p);
    n = 0; acc = 1'b0;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = in_ready;
      if (acc) last_acc_cyc = cyc;
      @(posedge clk); #2;
      n++;
    end
    if (!acc) begin
      checks++; errors++;
      $display("FAIL beat_accept: got no accept expected accept within 100 cycles");
    end
    in_valid = 1'b0; in_x = 8'($urandom); in_w = 8'($urandom); in_psum = 16'($urandom);
  endtask

  // gap_mode: 0 none, 1 idle cycle before every beat, 2 random idles
  task automatic send_window(input int gap_mode);
    for (int k = 0; k < TAPS; k++) begin
      if (gap_mode == 1 || (gap_mode == 2 && ($urandom % 2) == 1)) begin
        in_valid = 1'b0;
        @(posedge clk); #2;
      end
      send_beat(wx[k], ww[k], (k == 0) ? wpsum : int'($urandom % 65536));
    end
  endtask

  task automatic junk_drive(input bit junk);
    in_valid = junk ? 1'($urandom) : 1'b0;
    in_x = 8'($urandom); in_w = 8'($urandom); in_psum = 16'($urandom);
  endtask

  task automatic get_result(input int low, input bit junk,
                            output int res, output int vc, output int rise);
    int n;
    out_ready = (low == 0);
    n = 0; res = 0; vc = 0; rise = 0;
    while (!out_valid && n < 100) begin
      junk_drive(junk);
      @(posedge clk); #2;
      n++;
    end
    if (!out_valid) begin
      checks++; errors++;
      $display("FAIL result_wait: got no out_valid expected out_valid within 100 cycles");
    end else begin
      rise = cyc;
      res  = out_data;
      while (out_valid && vc < 20) begin
        if (vc == low) out_ready = 1'b1;
        junk_drive(junk);
        @(posedge clk); #2;
        vc++;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic fill(input int x0, input int xstep, input int w, input int p);
    for (int k = 0; k < TAPS; k++) begin
      wx[k] = x0 + xstep * k;
      ww[k] = w;
    end
    wpsum = p;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int res, vc, rise, rise1, res1, exp, dot, seen;
    logic signed [7:0]  t8;
    logic signed [15:0] t16;

    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    chk("reset_in_ready",  in_ready,  1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_busy",      busy,      0);
    chk("reset_out_data",  out_data,  0);

    fill(1, 1, 2, 10);
    send_window(0);
    get_result(0, 1'b0, res, vc, rise);
    chk("basic_result",  res, 40);
    chk("basic_latency", rise - last_acc_cyc, 7);

    fill(127, 0, 127, 0);
    send_window(0);
    get_result(0, 1'b0, res, vc, rise);
    chk("pos_sat", res, 32767);

    fill(-128, 0, 127, -100);
    send_window(0);
    get_result(0, 1'b1, res, vc, rise);
    chk("neg_sat", res, -32768);

    fill(1, 1, 2, 10);
    send_window(1);
    get_result(3, 1'b1, res, vc, rise);
    chk("gapped_result",     res, 40);
    chk("gapped_valid_hold", vc, 4);

    fill(7, 3, -5, 1234);
    send_window(0);
    repeat (2) begin @(posedge clk); #2; end
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    chk("rst_run_in_ready",  in_ready,  1);
    chk("rst_run_out_valid", out_valid, 0);
    chk("rst_run_row_x",     o_x,       0);
    seen = 0;
    repeat (10) begin
      if (out_valid) seen++;
      @(posedge clk); #2;
    end
    chk("rst_run_no_valid", seen, 0);
    fill(1, 0, 1, 0);
    send_window(0);
    get_result(0, 1'b0, res, vc, rise);
    chk("post_rst_result", res, 5);

    fill(1, 1, 2, 10);
    send_window(0);
    get_result(0, 1'b0, res1, vc, rise1);
    fill(1, 0, 1, 0);
    send_window(0);
    get_result(0, 1'b0, res, vc, rise);
    chk("b2b_first",  res1, 40);
    chk("b2b_second", res, 5);
    chk("b2b_period", rise - rise1, 12);

    for (int n = 0; n < 30; n++) begin
      for (int k = 0; k < TAPS; k++) begin
        t8 = 8'($urandom); wx[k] = t8;
        t8 = 8'($urandom); ww[k] = t8;
      end
      t16 = 16'($urandom); wpsum = t16;
      dot = wpsum;
      for (int k = 0; k < TAPS; k++) dot += wx[k] * ww[k];
      exp = sat16(dot);
      send_window(2);
      get_result(int'($urandom % 4), 1'b1, res, vc, rise);
      chk("random_result", res, exp);
    end

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
